// File: rtl/axi_mem_model.sv
// AXI4-lite slave memory model: configurable width, depth, base address, wait states and ROM mode.
// Out-of-range accesses return DECERR; writes in ROM mode return SLVERR.
module axi_mem_model #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DEPTH      = 81920,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int unsigned           RD_LAT     = 1,
   parameter int unsigned           WR_LAT     = 0,
   parameter bit                    READ_ONLY  = 1'b0,
   parameter string                 INIT_FILE  = ""
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic [2:0]              AWPROT,
   input  logic                    WVALID,
   output logic                    WREADY,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   output logic                    BVALID,
   input  logic                    BREADY,
   output logic [1:0]              BRESP,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic [2:0]              ARPROT,
   output logic                    RVALID,
   input  logic                    RREADY,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]              RRESP
);

   localparam int unsigned           STRB_W   = DATA_WIDTH / 8;
   localparam int unsigned           OFF_BITS = $clog2(STRB_W);
   localparam int unsigned           IDX_W    = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);

   typedef enum logic [1:0] {W_IDLE, W_LAT, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} r_state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   w_state_t              w_state, w_state_d;
   logic [3:0]            w_cnt, w_cnt_d;
   logic [ADDR_WIDTH-1:0] aw_addr, aw_addr_d;
   logic [DATA_WIDTH-1:0] w_data, w_data_d;
   logic [STRB_W-1:0]     w_strb, w_strb_d;
   logic                  have_aw, have_aw_d, have_w, have_w_d;
   logic                  awready_d, wready_d, bvalid_d;
   logic [1:0]            bresp_d;

   r_state_t              r_state, r_state_d;
   logic [3:0]            r_cnt, r_cnt_d;
   logic [ADDR_WIDTH-1:0] ar_addr, ar_addr_d;
   logic                  arready_d, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_d;
   logic [1:0]            rresp_d;

   logic                  mem_we_c;
   logic                  w_in_range_c, r_in_range_c;
   logic [IDX_W-1:0]      w_idx_c, r_idx_c;
   logic                  unused_prot;

   assign unused_prot = ^{AWPROT, ARPROT};

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] off;
      off = a - BASE_ADDR;
      return (a >= BASE_ADDR) && ((off >> OFF_BITS) < DEPTH_A);
   endfunction

   function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] off;
      off = a - BASE_ADDR;
      return IDX_W'(off >> OFF_BITS);
   endfunction

   assign w_in_range_c = in_range(aw_addr);
   assign w_idx_c      = idx_of(aw_addr);
   assign r_in_range_c = in_range(ar_addr);
   assign r_idx_c      = idx_of(ar_addr);

   // Write channel: collect AW and W in any order, wait WR_LAT, commit, hold B until BREADY.
   always_comb begin
      w_state_d = w_state;
      w_cnt_d   = w_cnt;
      aw_addr_d = aw_addr;
      w_data_d  = w_data;
      w_strb_d  = w_strb;
      have_aw_d = have_aw;
      have_w_d  = have_w;
      awready_d = AWREADY;
      wready_d  = WREADY;
      bvalid_d  = BVALID;
      bresp_d   = BRESP;
      mem_we_c  = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (AWVALID && AWREADY) begin
               aw_addr_d = AWADDR;
               have_aw_d = 1'b1;
               awready_d = 1'b0;
            end else if (!have_aw) begin
               awready_d = 1'b1;
            end
            if (WVALID && WREADY) begin
               w_data_d = WDATA;
               w_strb_d = WSTRB;
               have_w_d = 1'b1;
               wready_d = 1'b0;
            end else if (!have_w) begin
               wready_d = 1'b1;
            end
            if (have_aw_d && have_w_d) begin
               w_state_d = W_LAT;
               w_cnt_d   = 4'(WR_LAT);
            end
         end
         W_LAT: begin
            if (w_cnt == 4'd0) begin
               mem_we_c  = w_in_range_c && !READ_ONLY;
               w_state_d = W_RESP;
               bvalid_d  = 1'b1;
               bresp_d   = !w_in_range_c ? 2'b11 : (READ_ONLY ? 2'b10 : 2'b00);
            end else begin
               w_cnt_d = w_cnt - 4'd1;
            end
         end
         W_RESP: begin
            if (BREADY) begin
               bvalid_d  = 1'b0;
               have_aw_d = 1'b0;
               have_w_d  = 1'b0;
               awready_d = 1'b1;
               wready_d  = 1'b1;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read channel: accept AR, wait RD_LAT, register data/response, hold R until RREADY.
   always_comb begin
      r_state_d = r_state;
      r_cnt_d   = r_cnt;
      ar_addr_d = ar_addr;
      arready_d = ARREADY;
      rvalid_d  = RVALID;
      rdata_d   = RDATA;
      rresp_d   = RRESP;
      case (r_state)
         R_IDLE: begin
            if (ARVALID && ARREADY) begin
               ar_addr_d = ARADDR;
               arready_d = 1'b0;
               r_cnt_d   = 4'(RD_LAT);
               r_state_d = R_LAT;
            end else begin
               arready_d = 1'b1;
            end
         end
         R_LAT: begin
            if (r_cnt == 4'd0) begin
               rvalid_d  = 1'b1;
               rdata_d   = r_in_range_c ? mem[r_idx_c] : '0;
               rresp_d   = r_in_range_c ? 2'b00 : 2'b11;
               r_state_d = R_DATA;
            end else begin
               r_cnt_d = r_cnt - 4'd1;
            end
         end
         R_DATA: begin
            if (RREADY) begin
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         w_state <= W_IDLE;
         w_cnt   <= '0;
         aw_addr <= '0;
         w_data  <= '0;
         w_strb  <= '0;
         have_aw <= 1'b0;
         have_w  <= 1'b0;
         AWREADY <= 1'b0;
         WREADY  <= 1'b0;
         BVALID  <= 1'b0;
         BRESP   <= 2'b00;
         r_state <= R_IDLE;
         r_cnt   <= '0;
         ar_addr <= '0;
         ARREADY <= 1'b0;
         RVALID  <= 1'b0;
         RDATA   <= '0;
         RRESP   <= 2'b00;
      end else begin
         w_state <= w_state_d;
         w_cnt   <= w_cnt_d;
         aw_addr <= aw_addr_d;
         w_data  <= w_data_d;
         w_strb  <= w_strb_d;
         have_aw <= have_aw_d;
         have_w  <= have_w_d;
         AWREADY <= awready_d;
         WREADY  <= wready_d;
         BVALID  <= bvalid_d;
         BRESP   <= bresp_d;
         r_state <= r_state_d;
         r_cnt   <= r_cnt_d;
         ar_addr <= ar_addr_d;
         ARREADY <= arready_d;
         RVALID  <= rvalid_d;
         RDATA   <= rdata_d;
         RRESP   <= rresp_d;
      end
   end

   // Storage is never reset; a read captured on the commit edge sees the old word.
   always_ff @(posedge ACLK) begin
      if (mem_we_c) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (w_strb[b]) mem[w_idx_c][b*8 +: 8] <= w_data[b*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_mem_model.sv
// Bench for axi_mem_model: three instances (RAM with base offset, slow RAM, ROM) checked
// against a byte-level memory model through response scoreboards.
module tb_axi_mem_model;
   localparam int          N       = 3;
   localparam logic [31:0] BASE_A  = 32'h1000_0000;
   localparam int          DEPTH_T = 64;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        differ;
   } rsp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst     [N];
   logic        awvalid [N], awready [N], wvalid [N], wready [N];
   logic        bvalid  [N], bready  [N], arvalid [N], arready [N];
   logic        rvalid  [N], rready  [N];
   logic [31:0] awaddr  [N], wdata   [N], araddr  [N], rdata   [N];
   logic [3:0]  wstrb   [N];
   logic [1:0]  bresp   [N], rresp   [N];

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   rsp_t        wr_q [$];
   rsp_t        rd_q [$];
   logic [31:0] model [int];
   logic [31:0] rom_last = 32'h0;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < N; g++) begin : g_dut
      axi_mem_model #(
         .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH_T),
         .BASE_ADDR((g == 0) ? BASE_A : 32'h0),
         .RD_LAT((g == 1) ? 5 : 1), .WR_LAT((g == 1) ? 3 : 0),
         .READ_ONLY(g == 2), .INIT_FILE("")
      ) u_dut (
         .ACLK(clk), .ARESET(rst[g]),
         .AWVALID(awvalid[g]), .AWREADY(awready[g]), .AWADDR(awaddr[g]), .AWPROT(3'b000),
         .WVALID(wvalid[g]), .WREADY(wready[g]), .WDATA(wdata[g]), .WSTRB(wstrb[g]),
         .BVALID(bvalid[g]), .BREADY(bready[g]), .BRESP(bresp[g]),
         .ARVALID(arvalid[g]), .ARREADY(arready[g]), .ARADDR(araddr[g]), .ARPROT(3'b000),
         .RVALID(rvalid[g]), .RREADY(rready[g]), .RDATA(rdata[g]), .RRESP(rresp[g])
      );
   end

   function automatic logic [31:0] base_of(input int k);
      return (k == 0) ? BASE_A : 32'h0;
   endfunction
   function automatic int wlat_of(input int k);
      return (k == 1) ? 3 : 0;
   endfunction
   function automatic int rlat_of(input int k);
      return (k == 1) ? 5 : 1;
   endfunction
   function automatic bit in_rng(input int k, input logic [31:0] a);
      logic [31:0] off;
      off = a - base_of(k);
      return (a >= base_of(k)) && ((off >> 2) < 32'(DEPTH_T));
   endfunction
   function automatic int key_of(input int k, input logic [31:0] a);
      return k * 4096 + int'((a - base_of(k)) >> 2);
   endfunction

   // Issue one write (W trails AW by w_delay cycles), then check latency and BRESP.
   task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int w_delay, output int acc);
      rsp_t e;
      logic [31:0] cur;
      int n, lat;
      bit aw_done, w_done, aw_hs, w_hs;
      e.data = 32'h0;
      e.differ = 1'b0;
      if (!in_rng(k, a)) e.resp = 2'b11;
      else if (k == 2) begin
         e.resp = 2'b10;
         rom_last = d;
      end else begin
         e.resp = 2'b00;
         cur = model.exists(key_of(k, a)) ? model[key_of(k, a)] : 32'h0;
         for (int b = 0; b < 4; b++) if (s[b]) cur[b*8 +: 8] = d[b*8 +: 8];
         model[key_of(k, a)] = cur;
      end
      wr_q.push_back(e);
      awaddr[k] = a; wdata[k] = d; wstrb[k] = s;
      awvalid[k] = 1'b1;
      wvalid[k] = (w_delay == 0);
      n = 0; aw_done = 0; w_done = 0;
      while (!(aw_done && w_done) && n < 50) begin
         aw_hs = awvalid[k] && awready[k];
         w_hs  = wvalid[k] && wready[k];
         @(negedge clk);
         n++;
         if (aw_hs) begin awvalid[k] = 1'b0; aw_done = 1; end
         if (w_hs) begin wvalid[k] = 1'b0; w_done = 1; end
         if (aw_hs && !w_done) begin
            n_tests++;
            if (awready[k] !== 1'b0 || bvalid[k] !== 1'b0) begin
               n_fail++;
               $display("FAIL aw_stall k=%0d: awready=%b bvalid=%b, required 0 0", k, awready[k], bvalid[k]);
            end
         end
         if (!w_done && n == w_delay) wvalid[k] = 1'b1;
      end
      acc = cyc;
      lat = 0;
      while (bvalid[k] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
      e = wr_q.pop_front();
      n_tests++;
      if (lat != wlat_of(k) + 1) begin
         n_fail++;
         $display("FAIL wr_latency k=%0d: got %0d cycles, required %0d", k, lat, wlat_of(k) + 1);
      end
      n_tests++;
      if (bresp[k] !== e.resp) begin
         n_fail++;
         $display("FAIL bresp k=%0d addr=%h: got %b, required %b", k, a, bresp[k], e.resp);
      end
      @(negedge clk);
      n_tests++;
      if (bvalid[k] !== 1'b0 || awready[k] !== 1'b1) begin
         n_fail++;
         $display("FAIL b_done k=%0d: bvalid=%b awready=%b, required 0 1", k, bvalid[k], awready[k]);
      end
   endtask

   // Issue one read, optionally holding RREADY low for 'hold' cycles after RVALID.
   task automatic do_read(input int k, input logic [31:0] a, input int hold, output int acc);
      rsp_t e;
      int n, lat;
      if (!in_rng(k, a)) e = '{data: 32'h0, resp: 2'b11, differ: 1'b0};
      else if (k == 2) e = '{data: rom_last, resp: 2'b00, differ: 1'b1};
      else e = '{data: model[key_of(k, a)], resp: 2'b00, differ: 1'b0};
      rd_q.push_back(e);
      rready[k] = (hold == 0);
      araddr[k] = a;
      arvalid[k] = 1'b1;
      n = 0;
      while (arready[k] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      arvalid[k] = 1'b0;
      acc = cyc;
      lat = 0;
      while (rvalid[k] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
      e = rd_q.pop_front();
      n_tests++;
      if (lat != rlat_of(k) + 1) begin
         n_fail++;
         $display("FAIL rd_latency k=%0d: got %0d cycles, required %0d", k, lat, rlat_of(k) + 1);
      end
      n_tests++;
      if (rresp[k] !== e.resp) begin
         n_fail++;
         $display("FAIL rresp k=%0d addr=%h: got %b, required %b", k, a, rresp[k], e.resp);
      end
      n_tests++;
      if (e.differ ? (rdata[k] === e.data) : (rdata[k] !== e.data)) begin
         n_fail++;
         $display("FAIL rdata k=%0d addr=%h: got %h, required %s%h", k, a, rdata[k],
                  e.differ ? "not " : "", e.data);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         n_tests++;
         if (rvalid[k] !== 1'b1 || rdata[k] !== e.data) begin
            n_fail++;
            $display("FAIL r_hold k=%0d cycle %0d: rvalid=%b rdata=%h, required 1 %h", k, i, rvalid[k], rdata[k], e.data);
         end
      end
      rready[k] = 1'b1;
      @(negedge clk);
      n_tests++;
      if (rvalid[k] !== 1'b0) begin
         n_fail++;
         $display("FAIL r_done k=%0d: rvalid=%b, required 0", k, rvalid[k]);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      for (int k = 0; k < N; k++) begin
         n_tests++;
         if ({awready[k], wready[k], arready[k], bvalid[k], rvalid[k], bresp[k], rresp[k], rdata[k]} !== 41'h0) begin
            n_fail++;
            $display("FAIL reset_values k=%0d: ready=%b%b%b bvalid=%b rvalid=%b rdata=%h, required all 0",
                     k, awready[k], wready[k], arready[k], bvalid[k], rvalid[k], rdata[k]);
         end
      end
      for (int k = 0; k < N; k++) rst[k] = 1'b0;
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         n_tests++;
         if ({awready[k], wready[k], arready[k], bvalid[k], rvalid[k]} !== 5'b11100) begin
            n_fail++;
            $display("FAIL reset_release k=%0d: aw/w/ar ready, bvalid, rvalid = %b%b%b%b%b, required 11100",
                     k, awready[k], wready[k], arready[k], bvalid[k], rvalid[k]);
         end
      end
   endtask

   task automatic test_write_read();
      int t;
      do_write(0, BASE_A + 32'h10, 32'hDEADBEEF, 4'b1111, 0, t);
      do_read(0, BASE_A + 32'h10, 0, t);
   endtask

   task automatic test_partial_strobe();
      int t;
      do_write(0, BASE_A + 32'h10, 32'h00AA0000, 4'b0100, 3, t);
      do_read(0, BASE_A + 32'h10, 0, t);
      n_tests++;
      if (model[key_of(0, BASE_A + 32'h10)] !== 32'hDEAABEEF) begin
         n_fail++;
         $display("FAIL strobe_model: got %h, required DEAABEEF", model[key_of(0, BASE_A + 32'h10)]);
      end
      do_read(0, BASE_A + 32'h13, 0, t);
   endtask

   task automatic test_errors();
      int t;
      do_read(0, BASE_A + 32'(4 * DEPTH_T), 0, t);
      do_read(0, BASE_A - 32'h4, 0, t);
      do_write(0, BASE_A + 32'(4 * DEPTH_T), 32'h1234_5678, 4'b1111, 0, t);
      do_write(2, 32'h8, 32'hA5A5A5A5, 4'b1111, 0, t);
      do_read(2, 32'h8, 0, t);
   endtask

   task automatic test_latency_backpressure();
      int t;
      do_write(1, 32'h20, 32'h1234_5678, 4'b1111, 0, t);
      do_read(1, 32'h20, 4, t);
   endtask

   task automatic test_back_to_back();
      int a1, a2;
      do_write(0, BASE_A + 32'h40, 32'h0404_0404, 4'b1111, 0, a1);
      do_write(0, BASE_A + 32'h44, 32'h0505_0505, 4'b1111, 0, a2);
      n_tests++;
      if (a2 - a1 != 3) begin
         n_fail++;
         $display("FAIL wr_interval: got %0d cycles, required 3", a2 - a1);
      end
      do_read(0, BASE_A + 32'h40, 0, a1);
      do_read(0, BASE_A + 32'h44, 0, a2);
      n_tests++;
      if (a2 - a1 != 4) begin
         n_fail++;
         $display("FAIL rd_interval: got %0d cycles, required 4", a2 - a1);
      end
   endtask

   task automatic test_abort();
      int t;
      logic [31:0] a;
      a = BASE_A + 32'h30;
      do_write(0, a, 32'h3333_3333, 4'b1111, 0, t);
      n_tests++;
      if (awready[0] !== 1'b1 || wready[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_ready: awready=%b wready=%b, required 1 1", awready[0], wready[0]);
      end
      awaddr[0] = a; wdata[0] = 32'hBADB_AD00; wstrb[0] = 4'b1111;
      awvalid[0] = 1'b1; wvalid[0] = 1'b1;
      @(posedge clk);
      #1 rst[0] = 1'b1;
      @(negedge clk);
      awvalid[0] = 1'b0; wvalid[0] = 1'b0;
      n_tests++;
      if (bvalid[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_bvalid: got %b, required 0", bvalid[0]);
      end
      @(negedge clk);
      rst[0] = 1'b0;
      @(negedge clk);
      n_tests++;
      if (awready[0] !== 1'b1 || bvalid[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_release: awready=%b bvalid=%b, required 1 0", awready[0], bvalid[0]);
      end
      do_read(0, a, 0, t);
   endtask

   // AR is accepted one cycle before AW/W so read capture and write commit share an edge.
   task automatic test_collision();
      int t;
      logic [31:0] a;
      rsp_t er, ew;
      a = BASE_A + 32'h20;
      do_write(0, a, 32'h1111_1111, 4'b1111, 0, t);
      rd_q.push_back('{data: model[key_of(0, a)], resp: 2'b00, differ: 1'b0});
      model[key_of(0, a)] = 32'h2222_2222;
      wr_q.push_back('{data: 32'h0, resp: 2'b00, differ: 1'b0});
      araddr[0] = a; arvalid[0] = 1'b1;
      @(negedge clk);
      arvalid[0] = 1'b0;
      awaddr[0] = a; wdata[0] = 32'h2222_2222; wstrb[0] = 4'b1111;
      awvalid[0] = 1'b1; wvalid[0] = 1'b1;
      @(negedge clk);
      awvalid[0] = 1'b0; wvalid[0] = 1'b0;
      @(negedge clk);
      er = rd_q.pop_front();
      ew = wr_q.pop_front();
      n_tests++;
      if (rvalid[0] !== 1'b1 || rdata[0] !== er.data) begin
         n_fail++;
         $display("FAIL collision_read: rvalid=%b rdata=%h, required 1 %h", rvalid[0], rdata[0], er.data);
      end
      n_tests++;
      if (bvalid[0] !== 1'b1 || bresp[0] !== ew.resp) begin
         n_fail++;
         $display("FAIL collision_write: bvalid=%b bresp=%b, required 1 %b", bvalid[0], bresp[0], ew.resp);
      end
      @(negedge clk);
      do_read(0, a, 0, t);
   endtask

   initial begin
      for (int k = 0; k < N; k++) begin
         rst[k] = 1'b1;
         awvalid[k] = 1'b0; wvalid[k] = 1'b0; arvalid[k] = 1'b0;
         bready[k] = 1'b1; rready[k] = 1'b1;
         awaddr[k] = 32'h0; wdata[k] = 32'h0; araddr[k] = 32'h0; wstrb[k] = 4'h0;
      end
      test_reset();
      test_write_read();
      test_partial_strobe();
      test_errors();
      test_latency_backpressure();
      test_back_to_back();
      test_abort();
      test_collision();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached with %0d tests run", n_tests);
      $fatal(1, "time limit");
   end
endmodule
